// File: rtl/scope_capture_engine.sv
// NCH-channel capture engine: circular sample buffer with pre-trigger depth,
// hysteresis edge trigger and auto/normal/single/free-run modes.
module scope_capture_engine #(
    parameter int NCH     = 2,
    parameter int DW      = 10,
    parameter int DEPTH   = 600,
    parameter int AUTO_TO = 1200,
    localparam int AW     = $clog2(DEPTH),
    localparam int SW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK100MHz,
    input  logic              rst_n,
    input  logic              sample_valid,
    input  logic [NCH*DW-1:0] sample_data,
    input  logic              run,
    input  logic [1:0]        trig_mode,
    input  logic              trig_edge,
    input  logic [SW-1:0]     trig_src,
    input  logic [DW-1:0]     trig_level,
    input  logic [DW-1:0]     trig_hyst,
    input  logic [AW-1:0]     pretrig,
    input  logic [AW-1:0]     rd_addr,
    input  logic              rd_done,
    output logic [NCH*DW-1:0] rd_data,
    output logic              frame_ready,
    output logic              triggered,
    output logic [2:0]        state
);
    localparam int TW = $clog2(AUTO_TO + 1);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] AUTO_TW = TW'(AUTO_TO);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE   = 3'd1,
        S_ARMED = 3'd2,
        S_POST  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t cur_state, state_d;
    logic [NCH*DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, start_ptr, start_d, pre_cnt, pre_cnt_d, post_cnt, post_cnt_d;
    logic [AW-1:0] pe, fire_start, phys;
    logic [AW:0]   back, phys_sum;
    logic [TW-1:0] to_cnt, to_cnt_d, to_next;
    logic [DW-1:0] s, lvl_lo, lvl_hi;
    logic [DW:0]   hi_sum;
    logic qualifier, qual_d, single_hold, hold_d, ready_d, trig_d, enter_pre;
    logic wr_en, qual_set, edge_hit, real_fire, forced;

    assign state = cur_state;
    assign pe    = (pretrig > LAST) ? LAST : pretrig;
    assign wr_en = sample_valid &&
                   (cur_state == S_PRE || cur_state == S_ARMED || cur_state == S_POST);

    // Trigger channel; out-of-range selects fall back to channel 0.
    always_comb begin
        s = sample_data[DW-1:0];
        for (int k = 1; k < NCH; k++)
            if (int'(trig_src) == k) s = sample_data[k*DW +: DW];
    end

    assign lvl_lo    = (trig_level > trig_hyst) ? trig_level - trig_hyst : '0;
    assign hi_sum    = {1'b0, trig_level} + {1'b0, trig_hyst};
    assign lvl_hi    = hi_sum[DW] ? '1 : hi_sum[DW-1:0];
    assign qual_set  = trig_edge ? (s >= lvl_hi) : (s <= lvl_lo);
    assign edge_hit  = trig_edge ? (s <= trig_level) : (s >= trig_level);
    assign real_fire = qualifier && edge_hit;
    assign to_next   = (to_cnt == AUTO_TW) ? to_cnt : to_cnt + 1'b1;
    assign forced    = (trig_mode == 2'd3) || (trig_mode == 2'd0 && to_next == AUTO_TW);

    // Frame starts pe samples behind the fire sample, modulo DEPTH.
    assign back       = {1'b0, wr_ptr} + DEPTH_W - {1'b0, pe};
    assign fire_start = (back >= DEPTH_W) ? AW'(back - DEPTH_W) : AW'(back);

    always_comb begin
        state_d    = cur_state;
        pre_cnt_d  = pre_cnt;
        post_cnt_d = post_cnt;
        to_cnt_d   = to_cnt;
        qual_d     = qualifier;
        hold_d     = single_hold;
        ready_d    = frame_ready;
        trig_d     = triggered;
        start_d    = start_ptr;
        enter_pre  = 1'b0;
        if (sample_valid && (cur_state == S_PRE || cur_state == S_ARMED) && qual_set)
            qual_d = 1'b1;
        case (cur_state)
            S_IDLE: if (run && !single_hold) begin
                state_d   = S_PRE;
                enter_pre = 1'b1;
            end
            S_PRE: begin
                if (pre_cnt == pe) state_d = S_ARMED;
                else if (sample_valid) pre_cnt_d = pre_cnt + 1'b1;
            end
            S_ARMED: if (sample_valid) begin
                to_cnt_d = to_next;
                if (real_fire || forced) begin
                    start_d = fire_start;
                    trig_d  = real_fire;
                    if (pe == LAST) begin
                        state_d = S_DONE;
                        ready_d = 1'b1;
                    end else begin
                        post_cnt_d = LAST - pe;
                        state_d    = S_POST;
                    end
                end
            end
            S_POST: if (sample_valid) begin
                if (post_cnt == 1) begin
                    state_d = S_DONE;
                    ready_d = 1'b1;
                end else begin
                    post_cnt_d = post_cnt - 1'b1;
                end
            end
            S_DONE: if (rd_done) begin
                ready_d = 1'b0;
                if (trig_mode == 2'd2) begin
                    hold_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d   = S_PRE;
                    enter_pre = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (enter_pre) begin
            pre_cnt_d = '0;
            qual_d    = 1'b0;
            to_cnt_d  = '0;
        end
        if (!run) begin
            state_d = S_IDLE;
            ready_d = 1'b0;
            hold_d  = 1'b0;
        end
    end

    always_ff @(posedge CLK100MHz or negedge rst_n) begin
        if (!rst_n) begin
            cur_state   <= S_IDLE;
            wr_ptr      <= '0;
            start_ptr   <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            to_cnt      <= '0;
            qualifier   <= 1'b0;
            single_hold <= 1'b0;
            frame_ready <= 1'b0;
            triggered   <= 1'b0;
        end else begin
            cur_state   <= state_d;
            start_ptr   <= start_d;
            pre_cnt     <= pre_cnt_d;
            post_cnt    <= post_cnt_d;
            to_cnt      <= to_cnt_d;
            qualifier   <= qual_d;
            single_hold <= hold_d;
            frame_ready <= ready_d;
            triggered   <= trig_d;
            if (wr_en) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK100MHz) begin
        if (wr_en) mem[wr_ptr] <= sample_data;
    end

    // frame_ready/rd_done: frame is held stable from frame_ready rising until
    // the cycle after an rd_done pulse; rd_addr is a logical, oldest-first index.
    assign phys_sum = {1'b0, start_ptr} + {1'b0, rd_addr};
    assign phys     = (phys_sum >= DEPTH_W) ? AW'(phys_sum - DEPTH_W) : AW'(phys_sum);

    always_ff @(posedge CLK100MHz or negedge rst_n) begin
        if (!rst_n) rd_data <= '0;
        else if ({1'b0, rd_addr} >= DEPTH_W) rd_data <= '0;
        else rd_data <= mem[phys];
    end
endmodule

// File: tb/tb_scope_capture_engine.sv
// Directed bench for scope_capture_engine (NCH=2, DW=10, DEPTH=16, AUTO_TO=8).
module tb_scope_capture_engine;
    logic        CLK100MHz = 1'b0;
    logic        rst_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [19:0] sample_data = '0;
    logic        run = 1'b0;
    logic [1:0]  trig_mode = 2'd1;
    logic        trig_edge = 1'b0;
    logic [0:0]  trig_src = 1'b0;
    logic [9:0]  trig_level = 10'd500;
    logic [9:0]  trig_hyst = 10'd20;
    logic [3:0]  pretrig = 4'd4;
    logic [3:0]  rd_addr = '0;
    logic        rd_done = 1'b0;
    logic [19:0] rd_data;
    logic        frame_ready, triggered;
    logic [2:0]  state;

    int tests = 0;
    int fails = 0;
    logic [19:0] exp_q[$];
    logic [19:0] d;
    int last;

    scope_capture_engine #(.NCH(2), .DW(10), .DEPTH(16), .AUTO_TO(8)) dut (
        .CLK100MHz(CLK100MHz), .rst_n(rst_n), .sample_valid(sample_valid),
        .sample_data(sample_data), .run(run), .trig_mode(trig_mode),
        .trig_edge(trig_edge), .trig_src(trig_src), .trig_level(trig_level),
        .trig_hyst(trig_hyst), .pretrig(pretrig), .rd_addr(rd_addr),
        .rd_done(rd_done), .rd_data(rd_data), .frame_ready(frame_ready),
        .triggered(triggered), .state(state)
    );

    always #5 CLK100MHz = ~CLK100MHz;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK100MHz);
    endtask

    task automatic strobe(input logic [9:0] c0, input logic [9:0] c1);
        @(negedge CLK100MHz);
        sample_valid = 1'b1;
        sample_data  = {c1, c0};
        @(negedge CLK100MHz);
        sample_valid = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [19:0] q);
        @(negedge CLK100MHz);
        rd_addr = a;
        @(negedge CLK100MHz);
        q = rd_data;
    endtask

    task automatic chk_ch0(input string tag, input logic [3:0] a, input logic [9:0] exp);
        logic [19:0] q;
        rd(a, q);
        check(tag, {22'd0, q[9:0]}, {22'd0, exp});
    endtask

    task automatic pulse_done();
        @(negedge CLK100MHz);
        rd_done = 1'b1;
        @(negedge CLK100MHz);
        rd_done = 1'b0;
    endtask

    task automatic restart(input logic [1:0] m, input logic e, input logic [3:0] p);
        @(negedge CLK100MHz);
        run = 1'b0;
        @(negedge CLK100MHz);
        trig_mode = m; trig_edge = e; pretrig = p;
        trig_level = 10'd500; trig_hyst = 10'd20;
        run = 1'b1;
        cyc(1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset values
        cyc(2);
        check("rst_state", state, 0);
        check("rst_ready", frame_ready, 0);
        check("rst_trig", triggered, 0);
        check("rst_rd_data", rd_data, 0);
        rst_n = 1'b1;
        cyc(1);

        // normal rising ramp, pe=4
        restart(2'd1, 1'b0, 4'd4);
        check("t1_pre", state, 1);
        last = -1;
        for (int v = 0; v <= 1020 && !frame_ready; v += 10) begin
            strobe(10'(v), 10'(1023 - v));
            last = v;
        end
        check("t1_ready", frame_ready, 1);
        check("t1_last_sample", last, 610);
        check("t1_state_done", state, 4);
        check("t1_triggered", triggered, 1);
        for (int k = 0; k < 16; k++) exp_q.push_back({10'(1023 - (460 + 10*k)), 10'(460 + 10*k)});
        for (int k = 0; k < 16; k++) begin
            rd(4'(k), d);
            check($sformatf("t1_frame[%0d]", k), d, exp_q.pop_front());
        end
        pulse_done();
        check("t1_ready_clr", frame_ready, 0);
        check("t1_rearm_pre", state, 1);

        // falling edge: rising ramp must not fire, descending ramp fires at 493
        restart(2'd1, 1'b1, 4'd4);
        check("t2_ready_off", frame_ready, 0);
        for (int v = 0; v <= 1020; v += 10) strobe(10'(v), 10'd0);
        check("t2_no_fire_ready", frame_ready, 0);
        check("t2_no_fire_state", state, 2);
        last = -1;
        for (int v = 1023; v >= 3 && !frame_ready; v -= 10) begin
            strobe(10'(v), 10'd0);
            last = v;
        end
        check("t2_ready", frame_ready, 1);
        check("t2_last_sample", last, 383);
        check("t2_triggered", triggered, 1);
        chk_ch0("t2_addr4", 4'd4, 10'd493);
        chk_ch0("t2_addr0", 4'd0, 10'd533);
        chk_ch0("t2_addr15", 4'd15, 10'd383);

        // auto mode timeout, constant 300
        restart(2'd0, 1'b0, 4'd4);
        repeat (11) strobe(10'd300, 10'd300);
        check("t3_armed_7", state, 2);
        strobe(10'd300, 10'd300);
        check("t3_forced_post", state, 3);
        repeat (11) strobe(10'd300, 10'd300);
        check("t3_ready", frame_ready, 1);
        check("t3_not_triggered", triggered, 0);
        chk_ch0("t3_addr0", 4'd0, 10'd300);
        chk_ch0("t3_addr8", 4'd8, 10'd300);
        chk_ch0("t3_addr15", 4'd15, 10'd300);

        // hysteresis: 495/505 noise never qualifies, dip to 470 does
        restart(2'd1, 1'b0, 4'd4);
        for (int i = 0; i < 20; i++) strobe((i % 2) ? 10'd505 : 10'd495, 10'd0);
        check("t4_noise_state", state, 2);
        check("t4_noise_ready", frame_ready, 0);
        strobe(10'd470, 10'd0);
        check("t4_dip_state", state, 2);
        strobe(10'd505, 10'd0);
        check("t4_fire_post", state, 3);
        repeat (11) strobe(10'd500, 10'd0);
        check("t4_ready", frame_ready, 1);
        chk_ch0("t4_addr4", 4'd4, 10'd505);
        chk_ch0("t4_addr3", 4'd3, 10'd470);
        chk_ch0("t4_addr2", 4'd2, 10'd505);
        chk_ch0("t4_addr5", 4'd5, 10'd500);

        // single shot: holds in IDLE until run toggles
        restart(2'd2, 1'b0, 4'd4);
        repeat (5) strobe(10'd0, 10'd0);
        strobe(10'd600, 10'd0);
        repeat (11) strobe(10'd600, 10'd0);
        check("t5_ready", frame_ready, 1);
        pulse_done();
        check("t5_idle", state, 0);
        check("t5_ready_clr", frame_ready, 0);
        repeat (5) strobe(10'd0, 10'd0);
        check("t5_hold_idle", state, 0);
        restart(2'd2, 1'b0, 4'd4);
        check("t5_rearm_pre", state, 1);
        repeat (5) strobe(10'd0, 10'd0);
        strobe(10'd700, 10'd0);
        repeat (11) strobe(10'd700, 10'd0);
        check("t5_ready2", frame_ready, 1);
        chk_ch0("t5_addr4", 4'd4, 10'd700);
        chk_ch0("t5_addr3", 4'd3, 10'd0);

        // async reset mid-POST
        restart(2'd1, 1'b0, 4'd4);
        repeat (5) strobe(10'd0, 10'd0);
        strobe(10'd600, 10'd0);
        repeat (3) strobe(10'd600, 10'd0);
        check("t6_post", state, 3);
        rd(4'd4, d);
        check("t6_rd_before_rst", {22'd0, d[9:0]}, 600);
        rst_n = 1'b0;
        #1;
        check("t6_rst_state", state, 0);
        check("t6_rst_ready", frame_ready, 0);
        check("t6_rst_rd_data", rd_data, 0);
        check("t6_rst_trig", triggered, 0);
        run = 1'b0;
        pretrig = 4'd15;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
        check("t6_idle_run0", state, 0);

        // pe = DEPTH-1: POST skipped, DONE straight after the fire
        run = 1'b1;
        cyc(1);
        check("t7_pre", state, 1);
        for (int i = 0; i < 15; i++) strobe(10'(10 * (i + 1)), 10'd0);
        cyc(1);
        check("t7_armed", state, 2);
        strobe(10'd600, 10'd0);
        check("t7_done", state, 4);
        check("t7_ready", frame_ready, 1);
        check("t7_triggered", triggered, 1);
        chk_ch0("t7_addr0", 4'd0, 10'd10);
        chk_ch0("t7_addr14", 4'd14, 10'd150);
        chk_ch0("t7_addr15", 4'd15, 10'd600);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
